fpu_mul_seq: RTL
================

FPU_MUL_SEQ -- requirements
Module: fpu_mul_seq

Interface
REQ-001 The module SHALL have no parameters; widths are fixed to IEEE-754 single precision.
REQ-002 clk  input  1  single clock for all state; all registers update on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 start  input  1  request to begin a multiply; accepted only in IDLE.
REQ-005 opA  input  32  first operand, float register ReadData1 (fs).
REQ-006 opB  input  32  second operand, float register ReadData2 (ft).
REQ-007 destAddr  input  5  destination float register (fd), captured with the operands.
REQ-008 busy  output  1  high while an operation is in flight (any state other than IDLE).
REQ-009 done  output  1  one-cycle pulse; result, resultAddr and flags are valid in that cycle.
REQ-010 result  output  32  packed single-precision product.
REQ-011 resultAddr  output  5  captured destAddr, driven to the float regfile WriteRegister.
REQ-012 overflow, underflow, invalid  output  1 each  exception flags for the last completed operation.

Function
REQ-013 The FSM SHALL have the states IDLE, UNPACK, MULT, NORM and DONE.
REQ-014 IDLE transitions to UNPACK when start=1 at a clock edge. In the same edge the module SHALL capture opA, opB and destAddr.
REQ-015 UNPACK lasts 1 cycle:
- split sign, exponent and fraction;
- form 24-bit mantissas with the hidden bit;
- clear the 48-bit product register and the 5-bit iteration counter;
- classify each operand as zero, inf, NaN or normal.
REQ-016 Inputs with exp=0 (zero and denormal) SHALL be treated as signed zero (flush-to-zero).
REQ-017 MULT SHALL run exactly 24 cycles, performing one shift-add step per cycle on an LSB-first multiplier bit. The counter runs 0..23, and the state exits to NORM when the count reaches 23.
REQ-018 NORM lasts 1 cycle:
- sign = sA^sB;
- exp = eA+eB-127, computed in 10-bit signed arithmetic;
- if product[47]=1: fraction = product[46:24] and exp = exp+1;
- otherwise: fraction = product[45:23].
REQ-019 Rounding SHALL be truncation (round toward zero).
REQ-020 If the normal-path exp >= 255, the result SHALL be {sign, 8'hFF, 23'h0} with overflow=1.
REQ-021 If the normal-path exp <= 0, the result SHALL be {sign, 31'h0} with underflow=1.
REQ-022 If either operand is NaN, or the operands are inf×zero, the result SHALL be 32'h7FC00000 with invalid=1.
REQ-023 Inf × (normal or inf) SHALL give signed inf with no flag set.
REQ-024 Zero × (normal or zero) SHALL give signed zero with no flag set.
REQ-025 Special cases SHALL take the same latency as normal operands; the latency is fixed regardless of data.
REQ-026 DONE lasts 1 cycle with done=1, then transitions to IDLE.
REQ-027 Latency: if start is accepted at edge k, done SHALL be high in the cycle after edge k+26 (27 cycles total).
REQ-028 busy SHALL be high from edge k through the end of the DONE cycle.
REQ-029 A new start SHALL be accepted at the edge that leaves DONE only if the FSM is in IDLE; the minimum issue interval is therefore 28 cycles.
REQ-030 start asserted while busy=1 SHALL be ignored; captured operands and the operation in flight SHALL be unaffected.
REQ-031 result, resultAddr and the flags SHALL be updated only on entry to DONE, and SHALL hold until the next DONE.
REQ-032 Flags are mutually exclusive; at most one of overflow, underflow and invalid is set per operation.

Reset
REQ-033 While reset=1 at an edge, the following SHALL be forced:
- state=IDLE;
- busy=0, done=0;
- result=32'h0, resultAddr=5'h0;
- overflow=0, underflow=0, invalid=0.
REQ-034 Reset SHALL take priority over start at the same edge.
REQ-035 Reset mid-operation SHALL abort the operation with no done pulse, and the first start after reset deasserts SHALL be accepted normally.

Verification
REQ-036 opA=40000000 (2.0), opB=40400000 (3.0), destAddr=5 -> done exactly 27 cycles after acceptance, result=40C00000, resultAddr=5, flags 000.
REQ-037 opA=opB=3FC00000 (1.5) -> result=40100000 (2.25), which exercises the product[47] normalization shift.
REQ-038 opA=7F000000, opB=40000000 -> result=7F800000, overflow=1; opA=opB=00800000 -> result=00000000, underflow=1.
REQ-039 opA=7F800000, opB=00000000 -> result=7FC00000, invalid=1; opA=7FC00001, opB=3F800000 -> result=7FC00000, invalid=1.
REQ-040 Start 2.0×3.0, then pulse start with opA=40800000 at cycle 5 -> ignored, result=40C00000; the back-to-back start in the cycle after done is accepted.
REQ-041 Start an operation, assert reset at cycle 10 -> busy=0 and result=0 the next cycle, no done pulse; a following start 2.0×3.0 completes normally.

Source files
------------

// File: rtl/fpu_mul_seq.sv
// Sequential IEEE-754 single-precision multiplier.
// Operation: capture the operands, unpack and classify them, run a 24-step
// shift-add mantissa multiply, then normalize, truncate and pack the result.
// Denormal inputs are flushed to signed zero. Latency is a fixed 27 cycles
// from acceptance to the done pulse, whatever the data.
//
// Handshake: start is accepted only on an edge where the FSM is in IDLE
// (busy=0); start while busy is ignored. done is a one-cycle pulse. result,
// resultAddr and the flags are valid in the done cycle and hold until the
// next done.
module fpu_mul_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] opA,
    input  logic [31:0] opB,
    input  logic [4:0]  destAddr,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic [4:0]  resultAddr,
    output logic        overflow,
    output logic        underflow,
    output logic        invalid,
    output logic [2:0]  state_dbg
);

    typedef enum logic [2:0] {IDLE, UNPACK, MULT, NORM, DONE} state_t;

    state_t      state;
    logic [31:0] a_q, b_q;
    logic [4:0]  dest_q;
    logic        sign_a, sign_b;
    logic [7:0]  exp_a, exp_b;
    logic [23:0] mant_a, mant_b;
    logic [47:0] prod;
    logic [4:0]  cnt;
    logic        zero_a, inf_a, nan_a;
    logic        zero_b, inf_b, nan_b;

    // Next-cycle values computed from the unpacked operands.
    logic [24:0]        step_sum;
    logic signed [9:0]  exp_sum;
    logic signed [9:0]  exp_norm;
    logic [22:0]        frac_norm;
    logic               sign_r;
    logic [31:0]        res_next;
    logic               ovf_next, unf_next, inv_next;

    assign busy      = (state != IDLE);
    assign state_dbg = state;

    // One shift-add step: add the multiplicand into the upper half when the
    // current LSB of the multiplier is set; the whole product shifts right.
    always_comb begin
        step_sum = {1'b0, prod[47:24]} + (mant_b[0] ? {1'b0, mant_a} : 25'd0);
    end

    // Normalize, truncate and select the special-case result.
    always_comb begin
        sign_r   = sign_a ^ sign_b;
        exp_sum  = $signed({2'b00, exp_a}) + $signed({2'b00, exp_b}) - 10'sd127;
        exp_norm = exp_sum;
        frac_norm = prod[45:23];
        if (prod[47]) begin
            exp_norm  = exp_sum + 10'sd1;
            frac_norm = prod[46:24];
        end
        res_next = {sign_r, exp_norm[7:0], frac_norm};
        ovf_next = 1'b0;
        unf_next = 1'b0;
        inv_next = 1'b0;
        if (nan_a || nan_b || (inf_a && zero_b) || (zero_a && inf_b)) begin
            res_next = 32'h7FC0_0000;
            inv_next = 1'b1;
        end else if (inf_a || inf_b) begin
            res_next = {sign_r, 8'hFF, 23'h0};
        end else if (zero_a || zero_b) begin
            res_next = {sign_r, 31'h0};
        end else if (exp_norm >= 10'sd255) begin
            res_next = {sign_r, 8'hFF, 23'h0};
            ovf_next = 1'b1;
        end else if (exp_norm <= 10'sd0) begin
            res_next = {sign_r, 31'h0};
            unf_next = 1'b1;
        end
    end

    // Control FSM plus datapath registers; outputs change only entering DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            done       <= 1'b0;
            result     <= 32'h0;
            resultAddr <= 5'h0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
            invalid    <= 1'b0;
            a_q        <= 32'h0;
            b_q        <= 32'h0;
            dest_q     <= 5'h0;
            sign_a     <= 1'b0;
            sign_b     <= 1'b0;
            exp_a      <= 8'h0;
            exp_b      <= 8'h0;
            mant_a     <= 24'h0;
            mant_b     <= 24'h0;
            prod       <= 48'h0;
            cnt        <= 5'h0;
            zero_a     <= 1'b0;
            inf_a      <= 1'b0;
            nan_a      <= 1'b0;
            zero_b     <= 1'b0;
            inf_b      <= 1'b0;
            nan_b      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q    <= opA;
                        b_q    <= opB;
                        dest_q <= destAddr;
                        state  <= UNPACK;
                    end
                end
                UNPACK: begin
                    sign_a <= a_q[31];
                    sign_b <= b_q[31];
                    exp_a  <= a_q[30:23];
                    exp_b  <= b_q[30:23];
                    mant_a <= {1'b1, a_q[22:0]};
                    mant_b <= {1'b1, b_q[22:0]};
                    zero_a <= (a_q[30:23] == 8'h00);
                    inf_a  <= (a_q[30:23] == 8'hFF) && (a_q[22:0] == 23'h0);
                    nan_a  <= (a_q[30:23] == 8'hFF) && (a_q[22:0] != 23'h0);
                    zero_b <= (b_q[30:23] == 8'h00);
                    inf_b  <= (b_q[30:23] == 8'hFF) && (b_q[22:0] == 23'h0);
                    nan_b  <= (b_q[30:23] == 8'hFF) && (b_q[22:0] != 23'h0);
                    prod   <= 48'h0;
                    cnt    <= 5'h0;
                    state  <= MULT;
                end
                MULT: begin
                    prod   <= {step_sum, prod[23:1]};
                    mant_b <= {1'b0, mant_b[23:1]};
                    cnt    <= cnt + 5'd1;
                    if (cnt == 5'd23) begin
                        state <= NORM;
                    end
                end
                NORM: begin
                    result     <= res_next;
                    resultAddr <= dest_q;
                    overflow   <= ovf_next;
                    underflow  <= unf_next;
                    invalid    <= inv_next;
                    done       <= 1'b1;
                    state      <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
